// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU MEM stage (port 0) vs DMA/loader (port 1).
// Round-robin arbitration with bounded locked bursts and 1-cycle load return.
module dmem_arbiter #(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_e;

    localparam logic [2:0] BMAX = 3'(BURST_MAX);

    state_e      state_q, state_d;
    logic        rr_q, rr_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic        rvalid0_q, rvalid1_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic        g0, g1;
    logic        ld0, ld1;
    logic [2:0]  bnext;
    logic        room;

    // Owner keeps the port only while it keeps requesting.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset) begin
            if (state_q == OWN0 && req0) begin
                g0 = 1'b1;
            end else if (state_q == OWN1 && req1) begin
                g1 = 1'b1;
            end else if (req0 && req1) begin
                g0 = ~rr_q;
                g1 = rr_q;
            end else begin
                g0 = req0;
                g1 = req1;
            end
        end
    end

    assign bnext = {1'b0, bcnt_q} + 3'd1;
    assign room  = (bnext < BMAX);
    assign ld0   = g0 & ~we0;
    assign ld1   = g1 & ~we1;

    always_comb begin
        state_d = IDLE;
        bcnt_d  = 2'd0;
        rr_d    = rr_q;
        if (g0) begin
            if (lock0 && room) begin
                state_d = OWN0;
                bcnt_d  = bnext[1:0];
            end else begin
                rr_d = 1'b1;
            end
        end else if (g1) begin
            if (lock1 && room) begin
                state_d = OWN1;
                bcnt_d  = bnext[1:0];
            end else begin
                rr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            bcnt_q    <= 2'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            bcnt_q    <= bcnt_d;
            rvalid0_q <= ld0;
            rvalid1_q <= ld1;
            if (ld0) begin
                rdata0_q <= mem_read_data;
            end
            if (ld1) begin
                rdata1_q <= mem_read_data;
            end
        end
    end

    assign gnt0           = g0;
    assign gnt1           = g1;
    assign mem_address    = g1 ? addr1 : addr0;
    assign mem_write_data = g1 ? wdata1 : wdata0;
    assign mem_write      = (g0 & we0) | (g1 & we1);

    // A return pending into a reset cycle is dropped, not delivered.
    assign rvalid0 = rvalid0_q & ~reset;
    assign rvalid1 = rvalid1_q & ~reset;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scenario bench for dmem_arbiter; load returns are tracked by a
// cycle-tagged scoreboard checked every cycle on the falling edge.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write;

    logic [31:0] mem [0:63];

    typedef struct {
        int          cyc;
        bit          port;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          cyc;
    int          n_vec;
    int          n_err;
    bit          mon_en;
    logic [31:0] erd0, erd1;

    dmem_arbiter #(.BURST_MAX(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .req0           (req0),
        .req1           (req1),
        .we0            (we0),
        .we1            (we1),
        .lock0          (lock0),
        .lock1          (lock1),
        .addr0          (addr0),
        .addr1          (addr1),
        .wdata0         (wdata0),
        .wdata1         (wdata1),
        .gnt0           (gnt0),
        .gnt1           (gnt1),
        .rvalid0        (rvalid0),
        .rvalid1        (rvalid1),
        .rdata0         (rdata0),
        .rdata1         (rdata1),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_address[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Return-path monitor: rvalid/rdata checked every cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        logic ev0, ev1;
        if (mon_en) begin
            ev0 = 1'b0;
            ev1 = 1'b0;
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                if (e.cyc < cyc) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_stale: entry for cycle %0d unchecked at %0d",
                             e.cyc, cyc);
                end else if (e.port) begin
                    ev1  = 1'b1;
                    erd1 = e.data;
                end else begin
                    ev0  = 1'b1;
                    erd0 = e.data;
                end
            end
            if (reset) begin
                ev0 = 1'b0;
                ev1 = 1'b0;
            end
            n_vec++;
            if (rvalid0 !== ev0) begin
                n_err++;
                $display("FAIL rvalid0 cyc %0d: got %b want %b", cyc, rvalid0, ev0);
            end
            n_vec++;
            if (rvalid1 !== ev1) begin
                n_err++;
                $display("FAIL rvalid1 cyc %0d: got %b want %b", cyc, rvalid1, ev1);
            end
            n_vec++;
            if (rdata0 !== erd0) begin
                n_err++;
                $display("FAIL rdata0 cyc %0d: got %h want %h", cyc, rdata0, erd0);
            end
            n_vec++;
            if (rdata1 !== erd1) begin
                n_err++;
                $display("FAIL rdata1 cyc %0d: got %h want %h", cyc, rdata1, erd1);
            end
            if (reset) begin
                erd0 = 32'd0;
                erd1 = 32'd0;
            end
        end
    end

    // One cycle: drive at posedge+1, check grant/memory side at negedge.
    task automatic step(
        input logic        rst,
        input logic        r0, w0, l0,
        input logic [31:0] a0, d0,
        input logic        r1, w1, l1,
        input logic [31:0] a1, d1,
        input logic        eg0, eg1,
        input string       tag
    );
        logic [31:0] ea, ed;
        logic        ew;
        exp_t        e;
        reset  = rst;
        req0   = r0;
        we0    = w0;
        lock0  = l0;
        addr0  = a0;
        wdata0 = d0;
        req1   = r1;
        we1    = w1;
        lock1  = l1;
        addr1  = a1;
        wdata1 = d1;
        ea = eg1 ? a1 : a0;
        ed = eg1 ? d1 : d0;
        ew = (eg0 & w0) | (eg1 & w1);
        @(negedge clk);
        n_vec++;
        if (gnt0 !== eg0) begin
            n_err++;
            $display("FAIL %s gnt0: got %b want %b", tag, gnt0, eg0);
        end
        n_vec++;
        if (gnt1 !== eg1) begin
            n_err++;
            $display("FAIL %s gnt1: got %b want %b", tag, gnt1, eg1);
        end
        n_vec++;
        if (mem_write !== ew) begin
            n_err++;
            $display("FAIL %s mem_write: got %b want %b", tag, mem_write, ew);
        end
        n_vec++;
        if (mem_address !== ea) begin
            n_err++;
            $display("FAIL %s mem_address: got %h want %h", tag, mem_address, ea);
        end
        n_vec++;
        if (mem_write_data !== ed) begin
            n_err++;
            $display("FAIL %s mem_wdata: got %h want %h", tag, mem_write_data, ed);
        end
        if (eg0 && !w0) begin
            e.cyc  = cyc + 1;
            e.port = 1'b0;
            e.data = mem[a0[7:2]];
            sbq.push_back(e);
        end
        if (eg1 && !w1) begin
            e.cyc  = cyc + 1;
            e.port = 1'b1;
            e.data = mem[a1[7:2]];
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 32'h4, 32'h0, 0, 0, 0, 32'h8, 32'h0, 0, 0, tag);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {req0, req1, we0, we1, lock0, lock1} = '0;
        {addr0, addr1, wdata0, wdata1} = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(1, 1, 1, 1, 32'h30, 32'hCAFE0001,
             1, 1, 1, 32'h34, 32'hCAFE0002, 0, 0, "rst_both");
        step(1, 1, 1, 0, 32'h38, 32'h11111111,
             0, 0, 0, 32'h0, 32'h0, 0, 0, "rst_store");
    endtask

    task automatic test_single_load();
        step(0, 1, 0, 0, 32'h10, 32'h0,
             0, 0, 0, 32'h0, 32'h0, 1, 0, "ld0");
        idle("ld0_ret");
    endtask

    task automatic test_contention();
        step(0, 0, 0, 0, 32'h0, 32'h0,
             1, 0, 0, 32'h14, 32'h0, 0, 1, "pre1");
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 32'(8 * i), 32'h0,
                 1, 0, 0, 32'(8 * i + 4), 32'h0,
                 (i % 2) == 0, (i % 2) == 1, "contend");
        end
        idle("contend_end");
    endtask

    task automatic test_burst();
        step(0, 1, 0, 0, 32'h40, 32'h0,
             0, 0, 0, 32'h0, 32'h0, 1, 0, "pre0");
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 32'h44, 32'h0,
                 1, 0, 1, 32'(32'h80 + 4 * i), 32'h0,
                 i == 4, i < 4, "burst");
        end
        idle("burst_end");
    endtask

    task automatic test_store();
        step(0, 0, 0, 0, 32'h0, 32'h0,
             1, 1, 0, 32'h20, 32'h12345678, 0, 1, "st1");
        idle("st1_after");
    endtask

    task automatic test_early_release();
        step(0, 1, 0, 1, 32'h48, 32'h0,
             0, 0, 0, 32'h0, 32'h0, 1, 0, "own0");
        step(0, 0, 0, 1, 32'h4C, 32'h0,
             1, 0, 0, 32'h50, 32'h0, 0, 1, "release");
        step(0, 1, 0, 0, 32'h54, 32'h0,
             1, 0, 0, 32'h58, 32'h0, 1, 0, "rel_idle");
        idle("rel_end");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 32'h0, 32'h0,
                 1, 0, 0, 32'(32'hC0 + 4 * i), 32'h0, 0, 1, "b2b");
        end
        idle("b2b_ret");
        idle("b2b_hold");
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 0, 32'h0, 32'h0,
             1, 0, 1, 32'hD0, 32'h0, 0, 1, "own1");
        step(1, 1, 1, 0, 32'hD4, 32'hBAD0BAD0,
             1, 0, 1, 32'hD8, 32'h0, 0, 0, "rst_mid");
        step(0, 1, 0, 0, 32'hDC, 32'h0,
             1, 0, 0, 32'hE0, 32'h0, 1, 0, "post_rst");
        idle("rst_end");
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        cyc    = 0;
        mon_en = 1'b0;
        erd0   = 32'd0;
        erd1   = 32'd0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'hA5000000 ^ (32'(i) * 32'h01010101);
        end
        mem[4] = 32'hDEADBEEF;
        test_reset();
        test_single_load();
        test_contention();
        test_burst();
        test_store();
        test_early_release();
        test_back_to_back();
        test_reset_mid();
        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want finish");
        $fatal(1, "watchdog");
    end

endmodule
